// File: rtl/period_synth.sv
// period_synth: band-limited-free sawtooth oscillator driven by a period in
// samples. A serial restoring divider turns each requested period tau into a
// phase increment floor(2^PHASE_WIDTH / tau); a phase accumulator advanced on
// every audio tick produces an offset-binary sawtooth from its top bits.
module period_synth #(
  parameter  int WIDTH       = 16,
  parameter  int TAUMAX      = 2048,
  parameter  int PHASE_WIDTH = 24,
  localparam int TW          = $clog2(TAUMAX)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [TW-1:0]    tau_in,
  input  logic             tau_valid_in,
  input  logic             sample_tick_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             valid_out,
  output logic             busy_out
);

  // Counter width covers the PHASE_WIDTH+1 quotient bits of the divide.
  localparam int              CW       = $clog2(PHASE_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_TOP  = CW'(PHASE_WIDTH);
  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // The quotient of 2^PHASE_WIDTH by tau >= 2 never needs the top bit; if it
  // were ever set the increment clamps to full scale instead of wrapping.
  function automatic logic [PHASE_WIDTH-1:0] sat_inc(input logic [PHASE_WIDTH:0] q);
    if (q[PHASE_WIDTH]) begin
      return '1;
    end
    return q[PHASE_WIDTH-1:0];
  endfunction

  state_t                 state;
  logic [TW-1:0]          divisor;
  logic [TW-1:0]          rem;
  logic [PHASE_WIDTH-1:0] quo;
  logic [CW-1:0]          cnt;
  logic [PHASE_WIDTH-1:0] inc_reg;
  logic                   committed;
  logic                   pend_vld;
  logic [TW-1:0]          pend_tau;
  logic [PHASE_WIDTH-1:0] phase;

  logic                   tau_ok;
  logic [TW-1:0]          start_tau;
  logic [TW:0]            rem_sh;
  logic [TW-1:0]          rem_nx;
  logic                   q_bit;
  logic [PHASE_WIDTH:0]   q_nx;

  // Periods below two samples cannot be represented and are ignored.
  assign tau_ok = tau_valid_in && (tau_in >= TW'(2));

  // A fresh request this cycle beats anything already waiting.
  assign start_tau = tau_ok ? tau_in : pend_tau;

  // One restoring-division step. The dividend is 2^PHASE_WIDTH, so its only
  // set bit is the one fed in on the first step (cnt at its top value).
  always_comb begin
    rem_sh = {rem, (cnt == CNT_TOP)};
    q_bit  = 1'b0;
    rem_nx = rem_sh[TW-1:0];
    if (rem_sh >= {1'b0, divisor}) begin
      q_bit  = 1'b1;
      rem_nx = rem_sh[TW-1:0] - divisor;
    end
    q_nx = {quo, q_bit};
  end

  // Control FSM: accepts periods, runs the serial divide, commits the
  // increment and chains straight into a pending divide when one is queued.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      inc_reg   <= '0;
      committed <= 1'b0;
      pend_vld  <= 1'b0;
      pend_tau  <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (tau_ok) begin
            state    <= DIV;
            busy_out <= 1'b1;
            divisor  <= tau_in;
            rem      <= '0;
            quo      <= '0;
            cnt      <= CNT_TOP;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= q_nx[PHASE_WIDTH-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            inc_reg   <= sat_inc(q_nx);
            committed <= 1'b1;
            if (tau_ok || pend_vld) begin
              // Back-to-back divide: busy stays high, no RUN cycle in between.
              divisor  <= start_tau;
              rem      <= '0;
              quo      <= '0;
              cnt      <= CNT_TOP;
              pend_vld <= 1'b0;
            end else begin
              state    <= RUN;
              busy_out <= 1'b0;
            end
          end else if (tau_ok) begin
            pend_vld <= 1'b1;
            pend_tau <= tau_in;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

  // Audio-rate path: every tick emits one sample. Until an increment exists
  // the output is midscale silence and the phase is frozen; afterwards the
  // phase keeps running with whatever increment is committed, even mid-divide.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase      <= '0;
      sample_out <= MIDSCALE;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= sample_tick_in;
      if (sample_tick_in) begin
        if (committed) begin
          sample_out <= phase[PHASE_WIDTH-1 -: WIDTH];
          phase      <= phase + inc_reg;
        end else begin
          sample_out <= MIDSCALE;
        end
      end
    end
  end

endmodule

// File: tb/tb_period_synth.sv
// Scoreboarded bench for period_synth: a cycle-timed behavioural model pushes
// expected samples at each tick, a monitor pops them when valid_out appears.
module tb_period_synth;

  localparam int WIDTH  = 16;
  localparam int TAUMAX = 2048;
  localparam int PW     = 24;
  localparam int TW     = $clog2(TAUMAX);
  localparam logic [WIDTH-1:0] MID = 16'h8000;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic [TW-1:0]    tau_in = '0;
  logic             tau_valid_in = 1'b0;
  logic             sample_tick_in = 1'b0;
  logic [WIDTH-1:0] sample_out;
  logic             valid_out;
  logic             busy_out;

  period_synth #(.WIDTH(WIDTH), .TAUMAX(TAUMAX), .PHASE_WIDTH(PW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tau_in         (tau_in),
    .tau_valid_in   (tau_valid_in),
    .sample_tick_in (sample_tick_in),
    .sample_out     (sample_out),
    .valid_out      (valid_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got[$];
  bit   exp_busy = 1'b0;
  bit   mon_en   = 1'b0;

  // Behavioural model: a divide takes PW+1 cycles from acceptance to commit.
  int     m_left;
  int     m_cur;
  int     m_pend;
  longint m_inc;
  longint m_phase;
  bit     m_have;
  bit     m_acc;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input bit tick, input bit tv, input int tau);
    @(negedge clk_in);
    sample_tick_in = tick;
    tau_valid_in   = tv;
    tau_in         = TW'(tau);
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk_in);
    #2;
    rst_in         = 1'b0;
    sample_tick_in = 1'b0;
    tau_valid_in   = 1'b0;
    #1;
    if (chk) begin
      check("async reset sample_out", sample_out, MID);
      check("async reset valid_out", valid_out, 0);
      check("async reset busy_out", busy_out, 0);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic check_got(input string name, input int idx, input longint exp);
    check(name, (idx < got.size()) ? longint'(got[idx]) : -1, exp);
  endtask

  // Reference model
  initial begin
    m_left = 0; m_cur = 0; m_pend = -1; m_inc = 0; m_phase = 0; m_have = 0;
    forever begin
      @(posedge clk_in or negedge rst_in);
      if (!rst_in) begin
        m_left = 0; m_pend = -1; m_inc = 0; m_phase = 0; m_have = 0;
        exp_q.delete();
        exp_busy = 1'b0;
      end else begin
        m_acc = tau_valid_in && (int'(tau_in) >= 2);
        if (sample_tick_in) begin
          if (m_have) begin
            exp_q.push_back(WIDTH'(m_phase >> (PW - WIDTH)));
            m_phase = (m_phase + m_inc) % (longint'(1) << PW);
          end else begin
            exp_q.push_back(MID);
          end
        end
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_inc  = (longint'(1) << PW) / m_cur;
            m_have = 1'b1;
            if (m_acc) begin
              m_cur = int'(tau_in); m_left = PW + 1; m_pend = -1;
            end else if (m_pend >= 0) begin
              m_cur = m_pend; m_left = PW + 1; m_pend = -1;
            end
          end else if (m_acc) begin
            m_pend = int'(tau_in);
          end
        end else if (m_acc) begin
          m_cur = int'(tau_in); m_left = PW + 1;
        end
        exp_busy = (m_left > 0);
      end
    end
  end

  // Monitor
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk_in);
      if (rst_in && mon_en) begin
        check("busy_out", busy_out, exp_busy);
        check("valid_out", valid_out, exp_q.size() > 0);
        if (valid_out && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sample_out", sample_out, e);
          got.push_back(sample_out);
        end else if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb;
    int tick, tv, tau;
    // Reset state
    repeat (3) @(negedge clk_in);
    check("reset sample_out", sample_out, MID);
    check("reset valid_out", valid_out, 0);
    check("reset busy_out", busy_out, 0);
    rst_in = 1'b1;
    mon_en = 1'b1;

    // Ticks before any period: midscale, phase frozen
    got.delete();
    repeat (5) begin step(1, 0, 0); step(0, 0, 0); end
    step(0, 0, 0);
    check("idle tick count", got.size(), 5);
    for (int i = 0; i < 5; i++) check_got("idle midscale", i, MID);
    check("idle phase", dut.phase, 0);

    // tau=100: 25 busy cycles, then 0, 655, 1310
    step(0, 1, 100);
    nb = 0;
    repeat (30) begin step(0, 0, 0); if (busy_out) nb++; end
    check("busy cycles tau=100", nb, PW + 1);
    check("inc tau=100", dut.inc_reg, 167772);
    got.delete();
    repeat (3) begin step(1, 0, 0); step(0, 0, 0); end
    step(0, 0, 0);
    check_got("tau100 s0", 0, 0);
    check_got("tau100 s1", 1, 655);
    check_got("tau100 s2", 2, 1310);

    // tau=2 from phase 0, tau honoured on first edge after release
    do_reset(0);
    tau_valid_in = 1'b1;
    tau_in = TW'(2);
    repeat (30) step(0, 0, 0);
    got.delete();
    repeat (3) begin step(1, 0, 0); step(0, 0, 0); end
    check_got("tau2 s0", 0, 0);
    check_got("tau2 s1", 1, 16'h8000);
    check_got("tau2 s2", 2, 0);

    // tau=0 and tau=1 in RUN are ignored
    step(1, 1, 0); step(0, 0, 0); step(1, 1, 1); step(0, 0, 0); step(0, 0, 0);
    check("busy after tau<2", busy_out, 0);
    check("inc after tau<2", dut.inc_reg, 1 << 23);
    check_got("tau2 s3", 3, 16'h8000);
    check_got("tau2 s4", 4, 0);

    // Pending requests during a divide: newest wins, chained divide
    do_reset(0);
    step(0, 1, 100);
    for (int i = 1; i <= 60; i++) begin
      step(i % 2, (i == 5) || (i == 10), (i == 5) ? 50 : 200);
      if (i == 30) begin
        check("first commit inc", dut.inc_reg, 167772);
        check("chained busy", busy_out, 1);
      end
    end
    check("final inc", dut.inc_reg, 83886);
    check("final busy", busy_out, 0);

    // Reset in the middle of a divide
    step(0, 1, 300);
    repeat (10) step(0, 0, 0);
    do_reset(1);
    got.delete();
    repeat (4) begin step(1, 0, 0); step(0, 0, 0); end
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) check_got("post-reset midscale", i, MID);
    check("post-reset inc", dut.inc_reg, 0);
    step(1, 1, 100);
    repeat (40) step(1, 0, 0);

    // Randomized traffic
    repeat (3000) begin
      tick = ($urandom_range(0, 2) == 0);
      tv   = ($urandom_range(0, 39) == 0);
      tau  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3))
                                         : int'($urandom_range(2, TAUMAX - 1));
      step(tick[0], tv[0], tau);
    end
    repeat (3) step(0, 0, 0);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
